// File: rtl/seq_detector_param.sv
// seq_detector_param: parameterised serial pattern detector (Moore).
// Progress state Sk records how many leading pattern bits are matched by the
// most recent consumed bits; B is high while the full pattern is matched.
// Optional feature: define SEQ_DETECTOR_MATCH_COUNT_EN to add the saturating
// match_count output and its counter; without it clr clears state only.
module seq_detector_param #(
    parameter int               PAT_W   = 3,
    parameter logic [PAT_W-1:0] PATTERN = 3'b101,
    parameter int               CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             in_valid,
    input  logic             A,
    input  logic             overlap,
    output logic             B
`ifdef SEQ_DETECTOR_MATCH_COUNT_EN
    ,
    output logic [CNT_W-1:0] match_count
`endif
);

    localparam int ST_W = $clog2(PAT_W + 1);

    // Only idle and full-match are named; intermediate progress states are
    // the plain integers 1..PAT_W-1 carried in the same encoding.
    typedef enum logic [ST_W-1:0] {
        S_IDLE = ST_W'(0),
        S_FULL = ST_W'(PAT_W)
    } state_t;

    state_t state_q, state_d;
    int     kCur;
    int     kEff;
    int     kNext;

    // Length of the longest pattern prefix that ends the string formed by the
    // first k pattern bits followed by b. The exact-advance case (k+1 bits all
    // matching) falls out of the same search, as does the overlap restart.
    function automatic int longestBorder(input int k, input logic b);
        logic [31:0] pat;
        logic [31:0] hist;
        logic [31:0] mask;
        logic [31:0] pre;
        int          best;
        pat  = 32'(PATTERN);
        hist = ((pat >> (PAT_W - k)) << 1) | 32'(b);
        best = 0;
        for (int len = 1; len <= PAT_W; len++) begin
            if (len <= k + 1) begin
                mask = (32'd1 << len) - 32'd1;
                pre  = pat >> (PAT_W - len);
                if ((hist & mask) == pre) begin
                    best = len;
                end
            end
        end
        return best;
    endfunction

    // Next progress state: clear wins, illegal encodings recover, idle holds.
    always_comb begin
        state_d = state_q;
        kCur    = int'(state_q);
        kEff    = kCur;
        kNext   = kCur;
        if (clr) begin
            state_d = S_IDLE;
        end else if (kCur > PAT_W) begin
            state_d = S_IDLE;
        end else if (in_valid) begin
            if (kCur == PAT_W && !overlap) begin
                kEff = 0;
            end
            kNext   = longestBorder(kEff, A);
            state_d = state_t'(ST_W'(kNext));
        end
    end

    // Progress state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    assign B = (state_q == S_FULL);

`ifdef SEQ_DETECTOR_MATCH_COUNT_EN
    logic [CNT_W-1:0] count_q, count_d;

    // Count every consumed bit that lands in the full-match state, saturating.
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (in_valid && kCur <= PAT_W && state_d == S_FULL && count_q != '1) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    // Match counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign match_count = count_q;
`endif

endmodule

// File: tb/tb_seq_detector_param.sv
// tb_seq_detector_param: drives four differently parameterised detectors from
// one shared stimulus stream and compares them against a history-based model:
// a match exists whenever the last PAT_W bits consumed since the search
// started equal the pattern; non-overlap restarts the history after a match.
module tb_seq_detector_param;

    logic clk;
    logic rst;
    logic clr;
    logic in_valid;
    logic A;
    logic overlap;
    logic bDef, bSat, bP4, bP1;
`ifdef SEQ_DETECTOR_MATCH_COUNT_EN
    logic [7:0] cntDef;
    logic [1:0] cntSat;
    logic [7:0] cntP4;
    logic [3:0] cntP1;
`endif

    int compareCount  = 0;
    int mismatchCount = 0;

    int mWidth[4] = '{3, 3, 4, 1};
    int mPat[4]   = '{5, 5, 13, 0};
    int mMax[4]   = '{255, 3, 255, 15};
    int mHist[4];
    int mLen[4];
    bit mHit[4];
    int mCount[4];

    seq_detector_param #(.PAT_W(3), .PATTERN(3'b101), .CNT_W(8)) uDef (
        .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .A(A),
        .overlap(overlap), .B(bDef)
`ifdef SEQ_DETECTOR_MATCH_COUNT_EN
        , .match_count(cntDef)
`endif
    );

    seq_detector_param #(.PAT_W(3), .PATTERN(3'b101), .CNT_W(2)) uSat (
        .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .A(A),
        .overlap(overlap), .B(bSat)
`ifdef SEQ_DETECTOR_MATCH_COUNT_EN
        , .match_count(cntSat)
`endif
    );

    seq_detector_param #(.PAT_W(4), .PATTERN(4'b1101), .CNT_W(8)) uP4 (
        .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .A(A),
        .overlap(overlap), .B(bP4)
`ifdef SEQ_DETECTOR_MATCH_COUNT_EN
        , .match_count(cntP4)
`endif
    );

    seq_detector_param #(.PAT_W(1), .PATTERN(1'b0), .CNT_W(4)) uP1 (
        .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .A(A),
        .overlap(overlap), .B(bP1)
`ifdef SEQ_DETECTOR_MATCH_COUNT_EN
        , .match_count(cntP1)
`endif
    );

    // Free-running clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input int got, input int exp);
        compareCount++;
        if (got != exp) begin
            mismatchCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic modelClear();
        for (int i = 0; i < 4; i++) begin
            mHist[i]  = 0;
            mLen[i]   = 0;
            mHit[i]   = 1'b0;
            mCount[i] = 0;
        end
    endtask

    task automatic modelConsume(input logic a, input logic ov);
        for (int i = 0; i < 4; i++) begin
            if (mHit[i] && !ov) begin
                mHist[i] = 0;
                mLen[i]  = 0;
            end
            mHist[i] = ((mHist[i] << 1) | (a ? 1 : 0)) & 32'hFFFF;
            if (mLen[i] < 16) mLen[i]++;
            mHit[i] = (mLen[i] >= mWidth[i]) &&
                      ((mHist[i] & ((1 << mWidth[i]) - 1)) == mPat[i]);
            if (mHit[i] && mCount[i] < mMax[i]) mCount[i]++;
        end
    endtask

    task automatic checkAll(input string tag);
        bit obsB[4];
        obsB = '{bDef, bSat, bP4, bP1};
        for (int i = 0; i < 4; i++) begin
            checkOutput($sformatf("%s/B%0d", tag, i), int'(obsB[i]), int'(mHit[i]));
        end
`ifdef SEQ_DETECTOR_MATCH_COUNT_EN
        begin
            int obsC[4];
            obsC = '{int'(cntDef), int'(cntSat), int'(cntP4), int'(cntP1)};
            for (int i = 0; i < 4; i++) begin
                checkOutput($sformatf("%s/CNT%0d", tag, i), obsC[i], mCount[i]);
            end
        end
`endif
    endtask

    task automatic applyStimulus(input logic c, input logic iv, input logic a,
                                 input logic ov, input string tag);
        @(negedge clk);
        clr      = c;
        in_valid = iv;
        A        = a;
        overlap  = ov;
        @(posedge clk);
        if (c) modelClear();
        else if (iv) modelConsume(a, ov);
        #1;
        checkAll(tag);
    endtask

    task automatic feedBits(input logic [15:0] bits, input int n, input logic ov,
                            input string tag);
        for (int i = n - 1; i >= 0; i--) begin
            applyStimulus(1'b0, 1'b1, bits[4'(i)], ov, tag);
        end
    endtask

    // Reset asserted between edges and held across one edge with a valid bit.
    task automatic pulseReset(input string tag);
        @(negedge clk);
        #2;
        rst      = 1'b1;
        clr      = 1'b0;
        in_valid = 1'b1;
        A        = 1'b1;
        #1;
        modelClear();
        checkAll({tag, "/rstAsync"});
        @(posedge clk);
        #1;
        checkAll({tag, "/rstEdge"});
        @(negedge clk);
        rst      = 1'b0;
        in_valid = 1'b0;
    endtask

    initial begin
        rst      = 1'b1;
        clr      = 1'b0;
        in_valid = 1'b0;
        A        = 1'b0;
        overlap  = 1'b0;
        modelClear();
        #3;
        checkAll("reset");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Overlapping 10101: hits after bits 3 and 5.
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, "clr");
        feedBits(16'b10101, 5, 1'b1, "ovl");
        checkOutput("ovl/Bdef", int'(bDef), 1);
`ifdef SEQ_DETECTOR_MATCH_COUNT_EN
        checkOutput("ovl/cntDef", int'(cntDef), 2);
`endif

        // Non-overlapping 10101: only bit 3 completes a match.
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, "clr");
        feedBits(16'b10101, 5, 1'b0, "novl");
        checkOutput("novl/Bdef", int'(bDef), 0);
`ifdef SEQ_DETECTOR_MATCH_COUNT_EN
        checkOutput("novl/cntDef", int'(cntDef), 1);
`endif

        // Gaps with in_valid low hold the state, including the matched state.
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, "clr");
        feedBits(16'b10, 2, 1'b1, "gap");
        for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b0, 1'($urandom_range(0, 1)), 1'b1, "gap");
        feedBits(16'b1, 1, 1'b1, "gap");
        checkOutput("gap/Bdef", int'(bDef), 1);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 1'($urandom_range(0, 1)), 1'b1, "gapHold");
        checkOutput("gapHold/Bdef", int'(bDef), 1);

        // Reset mid-sequence abandons the partial match.
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, "clr");
        feedBits(16'b10, 2, 1'b1, "rstMid");
        pulseReset("rstMid");
        feedBits(16'b1, 1, 1'b1, "rstMid");
        checkOutput("rstMid/Bdef", int'(bDef), 0);
        feedBits(16'b101, 3, 1'b1, "rstMid");
        checkOutput("rstMid/Bend", int'(bDef), 1);
`ifdef SEQ_DETECTOR_MATCH_COUNT_EN
        checkOutput("rstMid/cntDef", int'(cntDef), 1);
`endif

        // Saturation of the 2-bit counter, then clear beating a valid bit.
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, "clr");
        feedBits(16'b101010101, 9, 1'b1, "sat");
`ifdef SEQ_DETECTOR_MATCH_COUNT_EN
        checkOutput("sat/cntSat", int'(cntSat), 3);
`endif
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, "satClr");
        checkOutput("satClr/Bsat", int'(bSat), 0);
`ifdef SEQ_DETECTOR_MATCH_COUNT_EN
        checkOutput("satClr/cntSat", int'(cntSat), 0);
`endif

        // Four-bit pattern 1101 with overlap on 1101101.
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, "clr");
        feedBits(16'b1101101, 7, 1'b1, "p4");
        checkOutput("p4/Bp4", int'(bP4), 1);
`ifdef SEQ_DETECTOR_MATCH_COUNT_EN
        checkOutput("p4/cntP4", int'(cntP4), 2);
`endif

        // Randomised traffic against the model.
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 49) == 0) begin
                pulseReset("rand");
            end else begin
                applyStimulus(1'($urandom_range(0, 19) == 0),
                              1'($urandom_range(0, 3) != 0),
                              1'($urandom_range(0, 1)),
                              1'($urandom_range(0, 1)), "rand");
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

endmodule

// File: doc/seq_detector_param.md
SEQ_DETECTOR_PARAM -- requirements
Module: seq_detector_param

Interface
REQ-001 SHALL have parameter PAT_W, default 3, pattern length in bits; legal range 1..16.
REQ-002 SHALL have parameter PATTERN, default 3'b101, PAT_W-bit target sequence; PATTERN[PAT_W-1] is the first bit expected.
REQ-003 SHALL have parameter CNT_W, default 8, match-counter width; legal range 1..32.
REQ-004 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port clr  input  1  synchronous clear of detector state and counter.
REQ-007 SHALL have port in_valid  input  1  qualifies A; a bit is consumed only when high.
REQ-008 SHALL have port A  input  1  serial data bit.
REQ-009 SHALL have port overlap  input  1  1 = overlapping detection, 0 = non-overlapping; sampled with each consumed bit.
REQ-010 SHALL have port B  output  1  Moore detect flag.
REQ-011 SHALL have port match_count  output  CNT_W  number of matches since reset/clear (present only per REQ-025).

Function
REQ-012 SHALL be a Moore machine with progress states S0..S(PAT_W); state k means the last k consumed bits equal the first k pattern bits; encoding width clog2(PAT_W+1).
REQ-013 SHALL, on a consumed bit b in state Sk (k<PAT_W), go to S(k+1) if b equals the (k+1)-th pattern bit, else to the longest proper prefix of the pattern that is a suffix of (matched prefix followed by b).
REQ-014 SHALL, on a consumed bit in S(PAT_W) with overlap=1, apply the REQ-013 fallback rule to the full pattern followed by b.
REQ-015 SHALL, on a consumed bit in S(PAT_W) with overlap=0, treat the bit as first bit of a fresh search: S1 if b equals the first pattern bit, else S0.
REQ-016 SHALL hold state unchanged in any cycle with in_valid=0.
REQ-017 SHALL drive B=1 iff current state is S(PAT_W), decoded from the state register only (no combinational path from A, in_valid, overlap); B rises one clk after the completing bit is consumed and remains high until the next consumed bit or clr.
REQ-018 SHALL increment match_count by 1 in the same edge that enters S(PAT_W), saturating at 2^CNT_W-1.
REQ-019 SHALL give clr priority over in_valid: on an edge with clr=1, state goes to S0 and match_count to 0, and the concurrent bit is discarded.
REQ-020 SHALL force any unreachable state encoding to S0 on the next edge.
REQ-021 SHALL, for PAT_W=1, enter S1 on every consumed bit equal to PATTERN[0] and S0 otherwise, independent of overlap.

Reset
REQ-022 SHALL, while rst=1, hold state at S0, B=0 and match_count=0, regardless of clk.
REQ-023 SHALL abandon any partial match when rst asserts mid-sequence; the first consumed bit after release is matched from S0.
REQ-024 SHALL consume no bit on a clk edge coincident with rst=1.

Configuration
REQ-025 SHALL compile match_count and its counter logic only when macro SEQ_DETECTOR_MATCH_COUNT_EN is defined; without it the port is absent, clr clears state only, and B behaviour is identical.

Verification
REQ-026 SHALL cover: defaults, overlap=1, in_valid=1, A=1,0,1,0,1 -> B high after 3rd and 5th bits, match_count=2.
REQ-027 SHALL cover: defaults, overlap=0, same A stream -> B high only after 3rd bit, match_count=1.
REQ-028 SHALL cover: A=1,0 then in_valid=0 for 5 cycles then A=1 -> state held through gap, B high one edge after final bit; B stays high during a following 3-cycle in_valid=0 gap.
REQ-029 SHALL cover: A=1,0 then rst pulse mid-cycle then A=1 -> B stays 0, match_count=0; subsequent 1,0,1 -> B=1, count=1.
REQ-030 SHALL cover: CNT_W=2, overlap=1, A=1,0,1,0,1,0,1,0,1 -> four matches, match_count saturates at 3; clr=1 with in_valid=1,A=1 on same edge -> state S0, count 0.
REQ-031 SHALL cover: PAT_W=4, PATTERN=4'b1101, overlap=1, A=1,1,0,1,1,0,1 -> B high after 4th and 7th bits, match_count=2.
